// File: rtl/count_seq_pkg.sv
// Shared types and default parameters for the counter-sequence checker.
package count_seq_pkg;

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} chk_state_t;

  localparam int DEF_W      = 4;
  localparam int DEF_LOCK_N = 3;
  localparam int DEF_LOSS_N = 2;
  localparam int DEF_ERR_W  = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [ERR_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst)
      value <= '0;
    else if (inc && (value != '1))
      value <= value + 1'b1;
  end

endmodule

// File: rtl/count_seq_checker.sv
// Monitors a valid-qualified up-counter stream, locks on consecutive increments and tallies breaks.
// Optional: define COUNT_SEQ_CHECKER_RESET_AWARE_EN to accept a 0 in LOCKED as a legal counter reset.
module count_seq_checker
  import count_seq_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int LOCK_N = DEF_LOCK_N,
  parameter int LOSS_N = DEF_LOSS_N,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     count_in,
  input  logic             count_vld,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [W-1:0]     exp_out
);

  localparam int MAX_N = (LOCK_N > LOSS_N) ? LOCK_N : LOSS_N;
  localparam int CW    = $clog2(MAX_N + 1);

  chk_state_t    state_q, state_d;
  logic [W-1:0]  exp_q, exp_d;
  logic [CW-1:0] match_q, match_d;
  logic [CW-1:0] miss_q, miss_d;
  logic          err_inc;
  logic          hit;

  assign hit = (count_in == exp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      exp_q     <= '0;
      match_q   <= '0;
      miss_q    <= '0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      err_pulse <= err_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_inc = 1'b0;
    if (count_vld) begin
      case (state_q)
        HUNT: begin
          exp_d   = count_in + 1'b1;
          match_d = '0;
          state_d = ACQ;
        end
        ACQ: begin
          if (hit) begin
            exp_d = exp_q + 1'b1;
            if (match_q + 1'b1 == CW'(LOCK_N)) begin
              match_d = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            exp_d   = count_in + 1'b1;
            match_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            exp_d  = exp_q + 1'b1;
            miss_d = '0;
          end
`ifdef COUNT_SEQ_CHECKER_RESET_AWARE_EN
          else if (count_in == '0) begin
            exp_d  = W'(1);
            miss_d = '0;
          end
`endif
          else begin
            err_inc = 1'b1;
            exp_d   = count_in + 1'b1;
            // Losing lock resets the miss run so the next LOCKED entry starts clean.
            if (miss_q + 1'b1 == CW'(LOSS_N)) begin
              miss_d  = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    locked  = (state_q == LOCKED);
    exp_out = exp_q;
  end

  sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .value (err_cnt)
  );

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed self-checking bench: default instance plus a narrow-tally instance (ERR_W=2, LOSS_N=8).
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] count_in, count_in2;
  logic       count_vld, count_vld2;
  logic       locked, err_pulse, locked2, err_pulse2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  logic [3:0] exp_out, exp_out2;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  count_seq_checker dut (
    .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .exp_out(exp_out)
  );

  count_seq_checker #(.W(4), .LOCK_N(3), .LOSS_N(8), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .count_in(count_in2), .count_vld(count_vld2),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2), .exp_out(exp_out2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic vld, input logic [3:0] val);
    count_vld = vld;
    count_in  = val;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic vld, input logic [3:0] val);
    count_vld2 = vld;
    count_in2  = val;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; count_vld = 1'b0; count_in = '0; count_vld2 = 1'b0; count_in2 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_locked", locked, 0);
    chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_exp", exp_out, 0);
    rst = 1'b0;

    // Continuous stream 0..15,0,1
    step(1, 0); step(1, 1); step(1, 2);
    chk("acq_not_locked", locked, 0);
    step(1, 3);
    chk("lock_after_4", locked, 1);
    chk("lock_exp", exp_out, 4);
    for (int i = 4; i < 16; i++) step(1, 4'(i));
    chk("pre_wrap_exp", exp_out, 0);
    step(1, 0);
    chk("wrap_no_err", err_pulse, 0);
    step(1, 1);
    chk("wrap_err_cnt", err_cnt, 0);
    chk("wrap_locked", locked, 1);
    chk("wrap_exp", exp_out, 2);

    // Single break: 2,3,4,5,7,8,9
    step(1, 2); step(1, 3); step(1, 4); step(1, 5);
    chk("pre_break_pulse", err_pulse, 0);
    step(1, 7);
    chk("break_pulse", err_pulse, 1);
    chk("break_cnt", err_cnt, 1);
    chk("break_locked", locked, 1);
    chk("break_reanchor", exp_out, 8);
    step(1, 8);
    chk("after_break_pulse", err_pulse, 0);
    step(1, 9);
    chk("after_break_cnt", err_cnt, 1);
    chk("after_break_exp", exp_out, 10);

    // Two consecutive breaks lose lock: 10,11,15,2
    step(1, 10); step(1, 11); step(1, 15);
    chk("loss1_pulse", err_pulse, 1);
    chk("loss1_locked", locked, 1);
    step(1, 2);
    chk("loss2_pulse", err_pulse, 1);
    chk("loss2_cnt", err_cnt, 3);
    chk("loss2_unlocked", locked, 0);
    step(1, 3);
    chk("hunt_anchor_exp", exp_out, 4);
    chk("hunt_no_pulse", err_pulse, 0);
    step(1, 4); step(1, 5);
    chk("reacq_not_locked", locked, 0);
    step(1, 6);
    chk("relock", locked, 1);

    // Valid gaps hold state
    step(1, 7);
    step(0, 4'hA);
    chk("idle1_exp", exp_out, 8);
    chk("idle1_pulse", err_pulse, 0);
    step(0, 0);
    chk("idle2_exp", exp_out, 8);
    chk("idle2_locked", locked, 1);
    step(1, 8);
    chk("gap_resume_pulse", err_pulse, 0);
    chk("gap_resume_exp", exp_out, 9);

    // Counter reset to 0 while locked: 9,10,0,1
    step(1, 9); step(1, 10); step(1, 0);
`ifdef COUNT_SEQ_CHECKER_RESET_AWARE_EN
    chk("zero_pulse", err_pulse, 0);
    chk("zero_cnt", err_cnt, 3);
`else
    chk("zero_pulse", err_pulse, 1);
    chk("zero_cnt", err_cnt, 4);
`endif
    chk("zero_locked", locked, 1);
    chk("zero_exp", exp_out, 1);
    step(1, 1);
    chk("zero_next_pulse", err_pulse, 0);
    chk("zero_next_locked", locked, 1);
    chk("zero_next_exp", exp_out, 2);

    // Saturation on ERR_W=2 instance with isolated mismatches
    step2(1, 0); step2(1, 1); step2(1, 2); step2(1, 3);
    chk("sat_locked", locked2, 1);
    step2(1, 9);
    chk("sat_m1_pulse", err_pulse2, 1);
    chk("sat_m1_cnt", err_cnt2, 1);
    step2(1, 10);
    step2(1, 3);
    chk("sat_m2_cnt", err_cnt2, 2);
    step2(1, 4);
    step2(1, 12);
    chk("sat_m3_cnt", err_cnt2, 3);
    step2(1, 13);
    step2(1, 6);
    chk("sat_m4_pulse", err_pulse2, 1);
    chk("sat_m4_cnt", err_cnt2, 3);
    step2(1, 7);
    step2(1, 14);
    chk("sat_m5_cnt", err_cnt2, 3);
    chk("sat_m5_locked", locked2, 1);
    step2(1, 15);
    chk("sat_exp", exp_out2, 0);

    // Reset mid-lock with a valid sample present
    rst = 1'b1;
    count_vld2 = 1'b1; count_in2 = 4'd0;
    step(1, 2);
    rst = 1'b0;
    count_vld2 = 1'b0;
    chk("mrst_locked", locked, 0);
    chk("mrst_pulse", err_pulse, 0);
    chk("mrst_exp", exp_out, 0);
    chk("mrst_cnt", err_cnt, 0);
    chk("mrst2_locked", locked2, 0);
    chk("mrst2_pulse", err_pulse2, 0);
    chk("mrst2_cnt", err_cnt2, 0);
    chk("mrst2_exp", exp_out2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
